// File: rtl/key_pkg.sv
// Shared types for the keyboard buffer: typematic state encoding and a
// helper that sizes the repeat counter.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } tm_state_e;

  // Counter must reach max(limit)-1; keep at least one bit when both limits are 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_typematic.sv
// Typematic auto-repeat FSM: emits a push on the first tick a key is seen,
// again after DELAY_TICKS ticks, then every RATE_TICKS ticks while held.
module key_typematic
  import key_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DELAY_TICKS = 300000,
  parameter int RATE_TICKS  = 30000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tick,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_code,
  output logic              o_push,
  output logic [DATA_W-1:0] o_push_data
);

  localparam int CNT_W = cnt_width(DELAY_TICKS, RATE_TICKS);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_TICKS - 1);

  tm_state_e         r_state, w_state;
  logic [DATA_W-1:0] r_prev, w_prev;
  logic [CNT_W-1:0]  r_cnt, w_cnt, w_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_prev  <= w_prev;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_prev      = r_prev;
    w_cnt       = r_cnt;
    w_limit     = (r_state == REPEAT) ? RATE_LAST : DELAY_LAST;
    o_push      = 1'b0;
    o_push_data = r_prev;
    if (i_clr) begin
      w_state = IDLE;
      w_prev  = '0;
      w_cnt   = '0;
    end else if (i_tick) begin
      case (r_state)
        IDLE: begin
          if (i_code != '0) begin
            o_push      = 1'b1;
            o_push_data = i_code;
            w_prev      = i_code;
            w_cnt       = '0;
            w_state     = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (i_code == '0) begin
            w_state = IDLE;
          end else if (i_code != r_prev) begin
            // A different key restarts the full initial delay.
            o_push      = 1'b1;
            o_push_data = i_code;
            w_prev      = i_code;
            w_cnt       = '0;
            w_state     = DELAY;
          end else if (r_cnt == w_limit) begin
            o_push  = 1'b1;
            w_cnt   = '0;
            w_state = REPEAT;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_fifo.sv
// Keyboard input buffer: typematic front end feeding a DEPTH-entry FIFO with
// a registered one-cycle read port, status flags and synchronous flush.
module key_fifo
  import key_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int DELAY_TICKS = 300000,
  parameter int RATE_TICKS  = 30000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_tick,
  input  logic [DATA_W-1:0]          key_code,
  input  logic                       rd_en,
  input  logic                       clr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_overflow;

  logic              w_push, w_pop, w_wr, w_drop;
  logic [DATA_W-1:0] w_push_data;

  key_typematic #(
    .DATA_W      (DATA_W),
    .DELAY_TICKS (DELAY_TICKS),
    .RATE_TICKS  (RATE_TICKS)
  ) u_typematic (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick      (key_tick),
    .i_clr       (clr),
    .i_code      (key_code),
    .o_push      (w_push),
    .o_push_data (w_push_data)
  );

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign count    = r_count;
  assign rd_data  = r_rd_data;
  assign overflow = r_overflow;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_pop  = rd_en & ~empty;
  assign w_wr   = w_push & (~full | rd_en);
  assign w_drop = w_push & full & ~rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (rd_en) r_rd_data <= w_pop ? r_mem[r_head] : '0;
      if (w_pop) r_head <= r_head + AW'(1);
      if (w_wr)  r_tail <= r_tail + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!clr && w_wr) r_mem[r_tail] <= w_push_data;
  end

endmodule

// File: tb/tb_key_fifo.sv
// Randomized and directed bench for key_fifo with a queue-based reference
// model and a scoreboard monitor for the read port.
module tb_key_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int DLY    = 4;
  localparam int RATE   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              key_tick = 1'b0;
  logic [DATA_W-1:0] key_code = '0;
  logic              rd_en = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              empty, full, overflow;
  logic [$clog2(DEPTH):0] count;

  key_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DELAY_TICKS(DLY), .RATE_TICKS(RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_tick(key_tick), .key_code(key_code),
    .rd_en(rd_en), .clr(clr), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents, sticky overflow, and key-hold tracking
  // expressed as "ticks elapsed since the last push of the held key".
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                m_ovf = 0;
  logic [DATA_W-1:0] mprev = '0;
  int                mel = 0;
  bit                mrep = 0;
  bit                rd_chk = 0;
  bit                mon_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 0;
    mprev = '0;
    mel   = 0;
    mrep  = 0;
  endtask

  task automatic model_step(input bit tk, input logic [DATA_W-1:0] kc, input bit rd, input bit cl);
    bit push;
    bit was_full;
    logic [DATA_W-1:0] got;
    push   = 0;
    rd_chk = rd | cl;
    if (cl) begin
      model_clear();
      exp_q.push_back('0);
      return;
    end
    if (tk) begin
      if (kc == '0) begin
        mprev = '0;
      end else if (kc != mprev) begin
        push = 1; mprev = kc; mel = 0; mrep = 0;
      end else begin
        mel++;
        if (mel == (mrep ? RATE : DLY)) begin
          push = 1; mel = 0; mrep = 1;
        end
      end
    end
    was_full = (mq.size() == DEPTH);
    if (rd) begin
      if (mq.size() != 0) got = mq.pop_front();
      else got = '0;
      exp_q.push_back(got);
    end
    if (push) begin
      if (!was_full || rd) mq.push_back(kc);
      else m_ovf = 1;
    end
  endtask

  // One clock cycle: drive, let the edge happen, then advance the model.
  task automatic cyc(input bit tk, input logic [DATA_W-1:0] kc, input bit rd, input bit cl);
    key_tick = tk; key_code = kc; rd_en = rd; clr = cl;
    @(posedge clk); #1;
    model_step(tk, kc, rd, cl);
  endtask

  task automatic do_reset();
    key_tick = 0; key_code = '0; rd_en = 0; clr = 0;
    rst_n = 0;
    model_clear();
    exp_q.delete();
    rd_chk = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Scoreboard monitor: compare read data and status on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_chk) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("rd_data", rd_data, exp_q.pop_front());
      end
      check("count", count, mq.size());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
    end
  end

  logic [DATA_W-1:0] cur;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("rst_rd_data", rd_data, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    mon_en = 1;

    // Hold 0x41 for 9 ticks: pushes on ticks 0, 4, 6, 8.
    for (int i = 0; i < 9; i++) begin
      cyc(1, 8'h41, 0, 0);
      cyc(0, 8'h41, 0, 0);
    end
    cyc(1, 8'h00, 0, 0);
    check("hold9_count", count, 4);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    check("hold9_drained", empty, 1);

    // Switch key before the delay expires.
    cyc(1, 8'h41, 0, 0);
    cyc(1, 8'h41, 0, 0);
    cyc(1, 8'h42, 0, 0);
    cyc(1, 8'h00, 0, 0);
    check("switch_count", count, 2);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);

    // Overflow: five distinct codes into four slots.
    for (int i = 1; i <= 5; i++) cyc(1, DATA_W'(i), 0, 0);
    check("ovf_full", full, 1);
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    cyc(1, 8'h06, 1, 0);
    check("full_pushpop_count", count, 4);
    cyc(1, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);

    // Pop while empty, then wrap the pointers with interleaved pops.
    cyc(0, 8'h00, 1, 0);
    check("empty_pop_data", rd_data, 0);
    check("empty_pop_count", count, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, DATA_W'(8'h10 + i), 0, 0);
      cyc(0, DATA_W'(8'h10 + i), i[0], 0);
    end
    cyc(1, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);

    // Flush while a key is held with three entries queued.
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h51, 0, 0);
    cyc(1, 8'h52, 0, 0);
    cyc(1, 8'h53, 0, 0);
    check("pre_clr_count", count, 3);
    cyc(0, 8'h53, 0, 1);
    check("clr_count", count, 0);
    check("clr_overflow", overflow, 0);
    check("clr_rd_data", rd_data, 0);
    cyc(1, 8'h53, 0, 0);
    check("clr_repush", count, 1);

    // Random traffic with a mid-run asynchronous reset.
    cur = 8'h53;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        cyc(0, cur, 0, 0);
        do_reset();
        check("midrst_count", count, 0);
      end
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: cur = 8'h00;
          1: cur = 8'h41;
          2: cur = 8'h42;
          default: cur = 8'h43;
        endcase
      end
      cyc(1'($urandom_range(0, 1)), cur, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end
    cyc(1, 8'h00, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    check("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_fifo.md
# key_fifo

Parametrised keyboard input buffer with typematic auto-repeat. It sits between the PS/2 scan-to-ASCII decoder and the CPU's memory-mapped keyboard port. Held keys are queued once, then repeated after a delay at a fixed rate. The CPU pops characters through a one-cycle read port. Over the earlier keyboard buffer it adds configurable width, depth and timing, a single clock domain, full/empty/count status, a sticky overflow flag and a synchronous flush.

## Interface
Parameters:
- DATA_W, 8: key code width; code 0 means "no key".
- DEPTH, 64: FIFO entries; power of two, ≥ 2.
- DELAY_TICKS, 300000: key_tick count from first push to first repeat; ≥ 1.
- RATE_TICKS, 30000: key_tick count between repeats; ≥ 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- key_tick  in  1  one-cycle sample strobe from the decoder clock divider.
- key_code  in  DATA_W  currently held key code, level-valued; 0 when no key is held.
- rd_en  in  1  CPU pop request.
- clr  in  1  synchronous flush.
- rd_data  out  DATA_W  popped code, registered.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky flag: a push was dropped.

## Operation
- Typematic FSM states: IDLE, DELAY, REPEAT. It evaluates only on cycles with key_tick=1 and holds otherwise.
- IDLE:
  - key_code≠0 → push key_code, prev←key_code, cnt←0, go to DELAY.
- DELAY:
  - key_code=0 → go to IDLE.
  - key_code≠prev → push the new code, prev←key_code, cnt←0, stay in DELAY.
  - cnt=DELAY_TICKS−1 → push prev, cnt←0, go to REPEAT.
  - Otherwise cnt+1.
- REPEAT: same rules as DELAY, with RATE_TICKS as the limit; the limit case stays in REPEAT.
- cnt is $clog2(max(DELAY_TICKS,RATE_TICKS)) bits wide and never exceeds its limit−1.
- FIFO:
  - head and tail pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is tracked separately, so full is count=DEPTH and empty is count=0.
- Pop:
  - rd_en=1 and not empty → rd_data←mem[head], head+1.
  - rd_en=1 and empty → rd_data←0.
  - rd_en=0 → rd_data holds its value.
- Push while full: data is dropped and overflow←1. Push while full with rd_en=1 in the same cycle is accepted; count stays DEPTH.
- Push and pop in the same cycle while empty: rd_data←0, the push is stored, there is no bypass.
- clr has priority over push and pop:
  - head, tail and count ← 0.
  - overflow ← 0, rd_data ← 0.
  - FSM goes to IDLE, prev ← 0, cnt ← 0.

## Timing
- Reset values:
  - Outputs: rd_data=0, empty=1, full=0, count=0, overflow=0.
  - Internal: FSM=IDLE, prev=0, cnt=0, head=tail=0.
- Push latency: entry is visible (count, empty) on the cycle after the key_tick edge.
- Pop latency: rd_data is valid the cycle after rd_en; a pop takes effect one entry per cycle, so back-to-back pops are allowed.
- Repeat spacing:
  - First repeat push comes exactly DELAY_TICKS key_ticks after the initial push.
  - Later repeats come every RATE_TICKS key_ticks.
- Reset asserted mid-operation clears all state immediately; FIFO contents are not required to clear (the pointers do).

## Structure
- Shared package key_pkg holds the typematic state enum (IDLE/DELAY/REPEAT).
- Sub-module key_typematic contains the FSM and counter. It outputs a push strobe and push data.
- key_fifo contains storage, pointers, count, flags and the read port.

## Test plan
- Reset, then check outputs → rd_data=0, empty=1, count=0, overflow=0.
- DELAY_TICKS=4, RATE_TICKS=2: hold 0x41 for 9 ticks, then release → pushes at ticks 0, 4, 6 and 8; count=4; four pops return 0x41 each.
- Hold 0x41 for 2 ticks, switch to 0x42 → 0x42 is pushed on the switch tick with no intervening 0x41 repeat; pops return 0x41, 0x42.
- DEPTH=4: push 5 distinct codes → full=1, count=4, overflow=1, fifth code lost. Push and pop in the same cycle while full → count stays 4 and the new code is retained.
- Pop while empty → rd_data=0 the next cycle and count stays 0. Fill 6 entries past pointer wrap (DEPTH=4, interleaved pops) → pops return codes in order.
- clr asserted while a key is held and count=3 → count=0, overflow=0, FSM restarts so the held key is re-pushed on the next key_tick.
